// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: sequences multi-cycle EX ops and derives the
// per-stage hold vector, the flush command and a saturating stall-cycle count.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_start,
    input  logic [5:0]  ex_cycles,
    input  logic        flush_req,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        ex_busy,
    output logic        ex_done,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic        ex_busy_r;
    logic        ex_done_r;
    logic [15:0] stall_count_r;

    logic        ex_hold_s;
    logic        id_hold_s;
    logic [5:0]  stall_s;
    logic        flush_s;
    logic [5:0]  load_cnt_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // Hazard decode: flush beats EX hold, EX hold beats the decode-stage hold.
    always_comb begin
        ex_hold_s  = 1'b0;
        id_hold_s  = 1'b0;
        stall_s    = STALL_NONE;
        flush_s    = 1'b0;
        load_cnt_s = (ex_cycles == 6'd0) ? 6'd1 : ex_cycles;
        if (!rst) begin
            stall_s = STALL_NONE;
            flush_s = 1'b0;
        end else begin
            ex_hold_s = ((state_r == ST_IDLE) && ex_start) || (state_r == ST_BUSY);
            id_hold_s = stallreq_id && (state_r != ST_BUSY);
            flush_s   = flush_req;
            if (flush_req) begin
                stall_s = STALL_NONE;
            end else if (ex_hold_s) begin
                stall_s = STALL_EX;
            end else if (id_hold_s) begin
                stall_s = STALL_ID;
            end else begin
                stall_s = STALL_NONE;
            end
        end
    end

    // EX sequencer; busy/done flags are registered alongside the state so
    // they follow it exactly, and a flush abandons any op in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 6'd0;
            ex_busy_r <= 1'b0;
            ex_done_r <= 1'b0;
        end else if (flush_req) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 6'd0;
            ex_busy_r <= 1'b0;
            ex_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ex_start) begin
                        state_r   <= ST_BUSY;
                        cnt_r     <= load_cnt_s;
                        ex_busy_r <= 1'b1;
                        ex_done_r <= 1'b0;
                    end else begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= cnt_r;
                        ex_busy_r <= 1'b0;
                        ex_done_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r - 6'd1;
                    if (cnt_r <= 6'd1) begin
                        state_r   <= ST_DONE;
                        ex_busy_r <= 1'b0;
                        ex_done_r <= 1'b1;
                    end else begin
                        state_r   <= ST_BUSY;
                        ex_busy_r <= 1'b1;
                        ex_done_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= cnt_r;
                    ex_busy_r <= 1'b0;
                    ex_done_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 6'd0;
                    ex_busy_r <= 1'b0;
                    ex_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Count every cycle that holds any stage, pinning at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= 16'd0;
        end else if (stall_s != STALL_NONE) begin
            stall_count_r <= sat_inc(stall_count_r);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall       = stall_s;
    assign flush       = flush_s;
    assign ex_busy     = ex_busy_r;
    assign ex_done     = ex_done_r;
    assign stall_count = stall_count_r;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 stallreq_id  input  1  load-use hazard stall request from the decode stage.
REQ-005 ex_start  input  1  one-cycle pulse; EX holds a multi-cycle ALU op (mult-acc/div).
REQ-006 ex_cycles  input  6  extra EX cycles for the op, sampled with ex_start; 0 is treated as 1.
REQ-007 flush_req  input  1  pipeline flush request (exception/redirect).
REQ-008 stall  output  6  per-stage hold vector {wb,mem,ex,id,if,pc}; bit0 = pc.
REQ-009 flush  output  1  flush command to IF/ID/EX pipeline registers.
REQ-010 ex_busy  output  1  high while a multi-cycle EX op is being sequenced.
REQ-011 ex_done  output  1  registered one-cycle pulse; EX result may advance this cycle.
REQ-012 stall_count  output  16  saturating count of cycles with stall != 0.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE, plus a 6-bit down-counter cnt.
REQ-014 IDLE with ex_start=1 and flush_req=0 SHALL load cnt = max(ex_cycles,1) and go to BUSY.
REQ-015 BUSY SHALL decrement cnt each cycle and, when cnt=1, go to DONE.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-017 ex_start SHALL be ignored in BUSY and DONE.
REQ-018 stall SHALL be combinational, with priority flush > EX hold > ID hold.
REQ-019 EX hold SHALL give stall = 6'b001111 in the ex_start cycle in IDLE and in every BUSY cycle, for a total of N+1 held cycles for cnt load N.
REQ-020 ID hold SHALL give stall = 6'b000111 when stallreq_id=1 and there is no EX hold, in IDLE or DONE.
REQ-021 No stall and no flush SHALL give stall = 6'b000000; DONE SHALL not hold EX.
REQ-022 flush SHALL equal flush_req combinationally, and stall SHALL be 6'b000000 in any cycle with flush_req=1.
REQ-023 flush_req in any state SHALL force IDLE and cnt=0 on the next edge, suppressing ex_done.
REQ-024 flush_req coincident with ex_start SHALL abort the op; BUSY is not entered.
REQ-025 ex_busy SHALL be 1 iff the state is BUSY.
REQ-026 ex_done SHALL be 1 iff the state is DONE.
REQ-027 stall_count SHALL increment on every edge where stall != 0.
REQ-028 stall_count SHALL saturate at 16'hFFFF with no wrap-around.

Reset
REQ-029 While rst=0, state SHALL be IDLE, cnt=0, ex_done=0 and stall_count=0, all immediately and asynchronously.
REQ-030 While rst=0, the combinational outputs SHALL be forced to stall=0, flush=0 and ex_busy=0.
REQ-031 Reset asserted mid-BUSY SHALL abort the op with no ex_done pulse after release.
REQ-032 After rst rises, the first active edge SHALL behave as in IDLE.

Verification
REQ-033 Idle: stallreq_id pulsed 1 cycle -> stall=000111 that cycle only; stall_count=1.
REQ-034 Multi-cycle: ex_start with ex_cycles=4 -> stall=001111 for 5 cycles; ex_busy for 4; ex_done one cycle after the last stall.
REQ-035 Zero length: ex_start with ex_cycles=0 -> 2 stall cycles, then ex_done.
REQ-036 Flush in BUSY: ex_cycles=8, flush_req at BUSY cycle 3 -> flush=1 and stall=0 that cycle; IDLE next; no ex_done.
REQ-037 Overlap: stallreq_id=1 throughout the BUSY op -> stall=001111 during BUSY; stall=000111 in DONE.
REQ-038 Saturation/reset: stall_count preloaded near FFFF stays at FFFF; rst=0 mid-BUSY clears all outputs at once.
